// File: rtl/solar_pkg.sv
// Shared solar-tracker servo timing constants and the servo frame FSM encoding.
// Used by both the vertical and horizontal servo drivers.
package solar_pkg;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned SERVO_PERIOD_CYC = 2_000_000;
  localparam int unsigned SERVO_MIN_PULSE  = 50_000;
  localparam int unsigned SERVO_STEP_CYC   = 1_000;
  localparam int unsigned SERVO_POS_MAX    = 200;
  localparam int unsigned SERVO_POS_W      = 8;

  typedef enum logic {
    StOff = 1'b0,
    StRun = 1'b1
  } servo_state_e;

  // Elaboration-time only; the datapath tracks the pulse incrementally.
  function automatic int unsigned servo_pulse(input int unsigned min_pulse,
                                              input int unsigned step_cyc,
                                              input int unsigned pos);
    return min_pulse + pos * step_cyc;
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Servo frame timer: OFF/RUN FSM, frame counter, first-cycle tick and last-cycle strobe.
// Also exposes next-state run/count so the PWM output can be registered without lag.
module pwm_frame_timer
  import solar_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = SERVO_PERIOD_CYC,
  parameter int unsigned CNT_W      = $clog2(SERVO_PERIOD_CYC)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en_i,
  output logic             frame_tick_o,
  output logic             last_o,
  output logic             run_next_o,
  output logic [CNT_W-1:0] cnt_next_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

  servo_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (state_q == StRun) && (cnt_q == CNT_LAST);

  // Enable is only honoured at frame end so a frame always completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StOff: begin
        cnt_d = '0;
        if (en_i) state_d = StRun;
      end
      StRun: begin
        if (last) begin
          cnt_d = '0;
          if (!en_i) state_d = StOff;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_tick_o = (state_q == StRun) && (cnt_q == '0);
  assign last_o       = last;
  assign run_next_o   = RST_N && (state_d == StRun);
  assign cnt_next_o   = cnt_d;

endmodule

// File: rtl/vert_servo_pwm.sv
// Vertical-axis servo driver: position index, once-per-frame stepping, PWM and end-stop flags.
// Define SERVO_CENTER_RESET_EN to reset to mid-travel instead of position 0.
module vert_servo_pwm
  import solar_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = SERVO_PERIOD_CYC,
  parameter int unsigned MIN_PULSE  = SERVO_MIN_PULSE,
  parameter int unsigned STEP_CYC   = SERVO_STEP_CYC,
  parameter int unsigned POS_MAX    = SERVO_POS_MAX,
  parameter int unsigned POS_W      = SERVO_POS_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SERVO_EN,
  input  logic             STEP_UP,
  input  logic             STEP_DOWN,
  output logic             PWM_OUT,
  output logic             PWM_limit,
  output logic             PWM_LOW_LIMIT,
  output logic [POS_W-1:0] POS,
  output logic             FRAME_TICK
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);

`ifdef SERVO_CENTER_RESET_EN
  localparam int unsigned POS_RST = POS_MAX / 2;
`else
  localparam int unsigned POS_RST = 0;
`endif

  localparam logic [POS_W-1:0] POS_TOP    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INIT   = POS_W'(POS_RST);
  localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(servo_pulse(MIN_PULSE, STEP_CYC, POS_RST));
  localparam logic [CNT_W-1:0] PULSE_STEP = CNT_W'(STEP_CYC);
  localparam logic             LIM_INIT   = (POS_RST == POS_MAX);
  localparam logic             LOW_INIT   = (POS_RST == 0);

  if (servo_pulse(MIN_PULSE, STEP_CYC, POS_MAX) >= PERIOD_CYC) begin : gen_pulse_err
    $error("vert_servo_pwm: maximum pulse does not fit inside the PWM period");
  end
  if (longint'(POS_MAX) > ((longint'(1) << POS_W) - 1)) begin : gen_pos_err
    $error("vert_servo_pwm: POS_W too narrow for POS_MAX");
  end

  logic             frame_last;
  logic             run_next;
  logic [CNT_W-1:0] cnt_next;

  pwm_frame_timer #(
    .PERIOD_CYC (PERIOD_CYC),
    .CNT_W      (CNT_W)
  ) u_frame_timer (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .en_i         (SERVO_EN),
    .frame_tick_o (FRAME_TICK),
    .last_o       (frame_last),
    .run_next_o   (run_next),
    .cnt_next_o   (cnt_next)
  );

  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic             lim_q, lim_d;
  logic             low_q, low_d;
  logic             pwm_q, pwm_d;

  // Steps commit on the last frame cycle so the new width covers the whole next frame.
  always_comb begin
    pos_d   = pos_q;
    pulse_d = pulse_q;
    if (frame_last && (STEP_UP != STEP_DOWN)) begin
      if (STEP_UP && (pos_q != POS_TOP)) begin
        pos_d   = pos_q + POS_W'(1);
        pulse_d = pulse_q + PULSE_STEP;
      end else if (STEP_DOWN && (pos_q != '0)) begin
        pos_d   = pos_q - POS_W'(1);
        pulse_d = pulse_q - PULSE_STEP;
      end
    end
    lim_d = (pos_d == POS_TOP);
    low_d = (pos_d == '0);
    // Compare against next count and width so the registered output is cycle-aligned.
    pwm_d = run_next && (cnt_next < pulse_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pos_q   <= POS_INIT;
      pulse_q <= PULSE_INIT;
      lim_q   <= LIM_INIT;
      low_q   <= LOW_INIT;
      pwm_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      pulse_q <= pulse_d;
      lim_q   <= lim_d;
      low_q   <= low_d;
      pwm_q   <= pwm_d;
    end
  end

  assign PWM_OUT       = pwm_q;
  assign PWM_limit     = lim_q;
  assign PWM_LOW_LIMIT = low_q;
  assign POS           = pos_q;

endmodule

// File: tb/tb_vert_servo_pwm.sv
// Self-checking bench for vert_servo_pwm with a frame-level reference model.
// Honours SERVO_CENTER_RESET_EN for the expected reset position.
module tb_vert_servo_pwm;

  localparam int P     = 100;
  localparam int MINP  = 5;
  localparam int STEPC = 1;
  localparam int PMAX  = 20;

`ifdef SERVO_CENTER_RESET_EN
  localparam int POS_RST = 10;
  localparam int EXP_P0  = 15;
`else
  localparam int POS_RST = 0;
  localparam int EXP_P0  = 5;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SERVO_EN = 1'b0;
  logic       STEP_UP = 1'b0;
  logic       STEP_DOWN = 1'b0;
  logic       PWM_OUT, PWM_limit, PWM_LOW_LIMIT, FRAME_TICK;
  logic [7:0] POS;

  vert_servo_pwm #(
    .PERIOD_CYC (P),
    .MIN_PULSE  (MINP),
    .STEP_CYC   (STEPC),
    .POS_MAX    (PMAX),
    .POS_W      (8)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .SERVO_EN      (SERVO_EN),
    .STEP_UP       (STEP_UP),
    .STEP_DOWN     (STEP_DOWN),
    .PWM_OUT       (PWM_OUT),
    .PWM_limit     (PWM_limit),
    .PWM_LOW_LIMIT (PWM_LOW_LIMIT),
    .POS           (POS),
    .FRAME_TICK    (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame state (on/off, cycle within frame, position).
  bit m_valid = 1'b0;
  bit m_on    = 1'b0;
  int m_cyc   = 0;
  int m_pos   = 0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_valid <= 1'b1;
      m_on    <= 1'b0;
      m_cyc   <= 0;
      m_pos   <= POS_RST;
    end else if (m_on) begin
      if (m_cyc == P - 1) begin
        m_cyc <= 0;
        m_on  <= SERVO_EN;
        if (STEP_UP && !STEP_DOWN)      m_pos <= (m_pos < PMAX) ? m_pos + 1 : PMAX;
        else if (STEP_DOWN && !STEP_UP) m_pos <= (m_pos > 0) ? m_pos - 1 : 0;
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else if (SERVO_EN) begin
      m_on  <= 1'b1;
      m_cyc <= 0;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("pwm_out", int'(PWM_OUT), int'(m_on && (m_cyc < MINP + m_pos * STEPC)));
      chk("frame_tick", int'(FRAME_TICK), int'(m_on && (m_cyc == 0)));
      chk("pos", int'(POS), m_pos);
      chk("pwm_limit", int'(PWM_limit), int'(m_pos == PMAX));
      chk("pwm_low_limit", int'(PWM_LOW_LIMIT), int'(m_pos == 0));
    end
  end

  task automatic wait_tick();
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge CLK);
      if (FRAME_TICK) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  task automatic measure_frame(output int hi, output int ticks);
    hi = 0;
    ticks = 0;
    for (int i = 0; i < P; i++) begin
      hi += int'(PWM_OUT);
      ticks += int'(FRAME_TICK);
      @(negedge CLK);
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  int hi, ticks;

  initial begin
    // Reset state
    skip(3);
    chk("rst_pwm", int'(PWM_OUT), 0);
    chk("rst_tick", int'(FRAME_TICK), 0);
    chk("rst_pos", int'(POS), POS_RST);
    chk("rst_low", int'(PWM_LOW_LIMIT), int'(POS_RST == 0));
    chk("rst_lim", int'(PWM_limit), 0);

    // 1: free-running frames at the reset position
    RST_N = 1'b1;
    SERVO_EN = 1'b1;
    wait_tick();
    measure_frame(hi, ticks);
    chk("t1_high", hi, EXP_P0);
    chk("t1_ticks", ticks, 1);

    // 2: hold STEP_UP 25 frames, saturate at the top
    STEP_UP = 1'b1;
    wait_tick();
    chk("t2_first_step", int'(POS), POS_RST + 1);
    chk("t2_low_falls", int'(PWM_LOW_LIMIT), 0);
    for (int f = 0; f < 24; f++) wait_tick();
    STEP_UP = 1'b0;
    chk("t2_pos_top", int'(POS), 20);
    chk("t2_lim", int'(PWM_limit), 1);
    measure_frame(hi, ticks);
    chk("t2_high", hi, 25);

    // 3: both requests -> no change; mid-frame request ignored
    STEP_UP = 1'b1;
    STEP_DOWN = 1'b1;
    wait_tick();
    STEP_UP = 1'b0;
    STEP_DOWN = 1'b0;
    chk("t3_both_pos", int'(POS), 20);
    measure_frame(hi, ticks);
    chk("t3_both_high", hi, 25);
    STEP_DOWN = 1'b1;
    for (int f = 0; f < 10; f++) wait_tick();
    STEP_DOWN = 1'b0;
    chk("t3_down_pos", int'(POS), 10);
    skip(50);
    STEP_UP = 1'b1;
    @(negedge CLK);
    STEP_UP = 1'b0;
    wait_tick();
    chk("t3_mid_ignored", int'(POS), 10);

    // 4: disable mid-frame; frame completes, then OFF; re-enable
    hi = 0;
    for (int i = 0; i < P; i++) begin
      if (i == 3) SERVO_EN = 1'b0;
      hi += int'(PWM_OUT);
      @(negedge CLK);
    end
    chk("t4_full_pulse", hi, 15);
    chk("t4_off_pwm", int'(PWM_OUT), 0);
    chk("t4_off_tick", int'(FRAME_TICK), 0);
    skip(5);
    chk("t4_off_pwm_later", int'(PWM_OUT), 0);
    SERVO_EN = 1'b1;
    @(negedge CLK);
    chk("t4_reenable_tick", int'(FRAME_TICK), 1);

    // 5: reset mid-pulse at the top position
    STEP_UP = 1'b1;
    for (int f = 0; f < 10; f++) wait_tick();
    STEP_UP = 1'b0;
    chk("t5_pos_top", int'(POS), 20);
    skip(2);
    chk("t5_pulse_before_rst", int'(PWM_OUT), 1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t5_rst_pwm", int'(PWM_OUT), 0);
    chk("t5_rst_pos", int'(POS), POS_RST);
    chk("t5_rst_lim", int'(PWM_limit), 0);
    chk("t5_rst_low", int'(PWM_LOW_LIMIT), int'(POS_RST == 0));
    RST_N = 1'b1;
    wait_tick();
    measure_frame(hi, ticks);
    chk("t5_high", hi, EXP_P0);

    // Downward saturation from the reset position
    STEP_DOWN = 1'b1;
    wait_tick();
    wait_tick();
    STEP_DOWN = 1'b0;
    chk("sat_low_pos", int'(POS), (POS_RST >= 2) ? POS_RST - 2 : 0);
    skip(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
